// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One bit per clock: shift-add multiply, restoring divide, sign fix-up in a final cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               is_div_q, is_div_d;
    logic               dbz_pend_q, dbz_pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_sh;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        is_div_d   = is_div_q;
        dbz_pend_d = dbz_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        a_mag  = (op[0] && a[WIDTH-1]) ? -a : a;
        b_mag  = (op[0] && b[WIDTH-1]) ? -b : b;
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        rem_sh = {rem_q, quot_q[WIDTH-1]};
        prod   = (sa_q ^ sb_q) ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d     = op[0] & a[WIDTH-1];
                    sb_d     = op[0] & b[WIDTH-1];
                    is_div_d = op[1];
                    mcand_d  = op[1] ? b_mag : a_mag;
                    acc_d    = {1'b0, {WIDTH{1'b0}}, b_mag};
                    quot_d   = a_mag;
                    rem_d    = '0;
                    cnt_d    = '0;
                    dbz_d    = 1'b0;
                    busy_d   = 1'b1;
                    // Divide by zero skips iteration; raw dividend parks in rem for hi.
                    if (op[1] && (b == '0)) begin
                        dbz_pend_d = 1'b1;
                        rem_d      = a;
                        state_d    = S_FIX;
                    end else begin
                        dbz_pend_d = 1'b0;
                        state_d    = op[1] ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL: begin
                acc_d = acc_q[0] ? ({sum, acc_q[WIDTH-1:0]} >> 1) : (acc_q >> 1);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_DIV: begin
                // rem_sh < 2*divisor, so a W-bit difference is exact when non-negative
                if (rem_sh >= {1'b0, mcand_q}) begin
                    rem_d  = rem_sh[WIDTH-1:0] - mcand_q;
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = rem_sh[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (dbz_pend_q) begin
                    hi_d  = rem_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else if (is_div_q) begin
                    hi_d = sa_q ? -rem_q : rem_q;
                    lo_d = (sa_q ^ sb_q) ? -quot_q : quot_q;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            is_div_q   <= 1'b0;
            dbz_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            is_div_q   <= is_div_d;
            dbz_pend_q <= dbz_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit for the MIPS datapath. Implements MULT, MULTU, DIV and DIVU.
- Holds results in HI/LO registers. Its hi/lo outputs feed the 4-to-1 result-select mux, alongside the ALU and shifter results.
- Uses a start/busy/done handshake. Computes one bit per clock (shift-add multiply, restoring divide).

Parameters:
- WIDTH, 32, operand width; hi/lo are each WIDTH bits; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when busy=0.
- op  input  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIV; sampled with start.
- a  input  WIDTH  rs operand (multiplicand/dividend); sampled with start.
- b  input  WIDTH  rt operand (multiplier/divisor); sampled with start.
- busy  output  1  operation in progress; new start ignored.
- done  output  1  one-cycle pulse; hi/lo updated in the same cycle.
- hi  output  WIDTH  MUL: product[2W-1:W]; DIV: remainder.
- lo  output  WIDTH  MUL: product[W-1:0]; DIV: quotient.
- div_by_zero  output  1  last DIV/DIVU had b==0; held until the next accepted start.

Behaviour:
- Single clock domain. Reset is synchronous, active-high.
- Reset values: busy=0, done=0, hi=0, lo=0, div_by_zero=0, FSM=IDLE. Reset mid-operation aborts the operation; no partial result reaches hi/lo.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE:
  - start=1 at edge E0 latches op, a and b.
  - For signed ops, latches the operand magnitudes and sign flags sa=a[W-1], sb=b[W-1]. For unsigned ops, sa=sb=0.
  - Clears the iteration counter and div_by_zero. Sets busy=1.
  - Moves to MUL (op[1]=0) or DIV (op[1]=1).
- Divide by zero: a DIV/DIVU with b==0 goes straight to FIX. At E1: hi=a (raw), lo={WIDTH{1}}, div_by_zero=1, done=1, busy=0.
- MUL: at each edge, if the multiplier LSB is 1, add the multiplicand into the upper accumulator half. Then shift the 2W+1-bit accumulator right by 1. After WIDTH edges (E1..E32 for WIDTH=32), go to FIX.
- DIV: at each edge, shift {rem,quot} left by 1, then trial-subtract the divisor from rem.
  - If the result is non-negative, keep it and set quot LSB=1.
  - Otherwise restore rem and set quot LSB=0.
  - After WIDTH edges, go to FIX.
- FIX (edge E33):
  - MUL: negate the 2W-bit product if sa^sb.
  - DIV: negate the quotient if sa^sb; negate the remainder if sa.
  - Load hi/lo, set done=1, busy=0, return to IDLE.
- Latency: done is high in the cycle after E(WIDTH+1), i.e. 33 edges after start is accepted (1 edge for divide by zero). busy is high exactly from after E0 until done rises.
- done is high for exactly one cycle. hi/lo hold their value from that edge until the next done or reset.
- start while busy=1 is ignored; no queueing, and the in-flight operands are unaffected.
- start while done=1 is accepted, because busy=0 in that cycle.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. Magnitude arithmetic wraps naturally; no trap.
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned WIDTH bits.
- MULT/MULTU always produce the full 2W-bit result; nothing is truncated.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done exactly 33 edges after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> done 1 edge after start; div_by_zero=1, hi=0x1234, lo=0xFFFFFFFF. The next accepted start clears div_by_zero.
- Start MULTU 3x5, then pulse start with DIVU 9/3 at cycle 10 -> second request ignored; result hi=0, lo=15.
- Start MULT 2x2 while done=1 -> accepted the same cycle; result lo=4.
- Start MULTU, assert reset at cycle 15 -> next cycle busy=0, done=0, hi=lo=0. No done pulse follows, and a later start runs normally.
